// File: rtl/debug_sequencer_if.sv
// Command/response, core-handshake and debug-strobe signals of debug_sequencer.
// master = command issuer plus core side, slave = the sequencer.
interface debug_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [7:0]        CMD_DATA;

  logic              RSP_VALID;
  logic [7:0]        RSP_DATA;
  logic              RSP_ERR;

  logic              DEBUG_REQUEST;
  logic              DEBUG_ACK;
  logic [7:0]        DEBUG_DATA;
  logic              D_DOn;
  logic              D_MIn;
  logic              D_ROn;
  logic              D_Jn;
  logic              D_RI;
  logic [7:0]        BUS;

  modport master (
    output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, DEBUG_ACK, BUS,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR,
    input  DEBUG_REQUEST, DEBUG_DATA, D_DOn, D_MIn, D_ROn, D_Jn, D_RI
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, DEBUG_ACK, BUS,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR,
    output DEBUG_REQUEST, DEBUG_DATA, D_DOn, D_MIn, D_ROn, D_Jn, D_RI
  );
endinterface

// File: rtl/debug_sequencer.sv
// Debug sequencer: takes core bus ownership and runs memory write/read or PC load.
// Optional REQ timeout enabled by defining DEBUG_SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a command
// REQ     | DEBUG_REQUEST high, waiting for DEBUG_ACK
// ADDR    | address driven into MAR
// DATA    | write data driven into RAM
// READ    | RAM driven onto bus, captured at end of cycle
// JUMP    | address driven into PC
// RELEASE | request dropped, waiting for DEBUG_ACK low
// RESP    | one-cycle response pulse
module debug_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input logic               CLK,
  input logic               RESETn,
  debug_sequencer_if.slave  dbg
);

  if (TIMEOUT < 1 || TIMEOUT > 255 || ADDR_W < 1 || ADDR_W > 8) begin : g_bad_param
    $error("debug_sequencer: TIMEOUT must be 1..255 and ADDR_W 1..8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_READ,
    S_JUMP,
    S_RELEASE,
    S_RESP
  } state_t;

  typedef struct packed {
    logic       ready;
    logic       valid;
    logic       req;
    logic [7:0] dd;
    logic       do_n;
    logic       mi_n;
    logic       ro_n;
    logic       j_n;
    logic       ri;
  } ctl_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SETPC = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t     state;
  ctl_t       ctl_q;
  logic [1:0] op_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       err_q;
  logic       rsp_err_q;
  logic [7:0] rsp_data_q;

`ifdef DEBUG_SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;
`endif

  // Output image of a state; registered together with the state so strobes are glitch-free.
  function automatic ctl_t ctl_for(state_t s, logic [7:0] a, logic [7:0] d);
    ctl_t c;
    c = '{ready: 1'b0, valid: 1'b0, req: 1'b0, dd: 8'h00,
          do_n: 1'b1, mi_n: 1'b1, ro_n: 1'b1, j_n: 1'b1, ri: 1'b0};
    case (s)
      S_IDLE:  c.ready = 1'b1;
      S_REQ:   c.req = 1'b1;
      S_ADDR:  begin c.req = 1'b1; c.dd = a; c.do_n = 1'b0; c.mi_n = 1'b0; end
      S_DATA:  begin c.req = 1'b1; c.dd = d; c.do_n = 1'b0; c.ri = 1'b1; end
      S_READ:  begin c.req = 1'b1; c.ro_n = 1'b0; end
      S_JUMP:  begin c.req = 1'b1; c.dd = a; c.do_n = 1'b0; c.j_n = 1'b0; end
      S_RESP:  c.valid = 1'b1;
      default: c.ready = 1'b0;
    endcase
    return c;
  endfunction

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= S_IDLE;
      ctl_q      <= ctl_for(S_IDLE, 8'h00, 8'h00);
      op_q       <= 2'b00;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      err_q      <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= 8'h00;
`ifdef DEBUG_SEQ_TIMEOUT_EN
      to_cnt     <= 8'h00;
`endif
    end else begin
      rsp_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dbg.CMD_VALID) begin
            op_q       <= dbg.CMD_OP;
            addr_q     <= 8'(dbg.CMD_ADDR);
            data_q     <= dbg.CMD_DATA;
            rsp_data_q <= 8'h00;
            if (dbg.CMD_OP == OP_RSVD) begin
              state     <= S_RESP;
              ctl_q     <= ctl_for(S_RESP, addr_q, data_q);
              err_q     <= 1'b1;
              rsp_err_q <= 1'b1;
            end else begin
              state <= S_REQ;
              ctl_q <= ctl_for(S_REQ, addr_q, data_q);
              err_q <= 1'b0;
`ifdef DEBUG_SEQ_TIMEOUT_EN
              to_cnt <= 8'h00;
`endif
            end
          end
        end

        S_REQ: begin
          if (dbg.DEBUG_ACK) begin
            if (op_q == OP_SETPC) begin
              state <= S_JUMP;
              ctl_q <= ctl_for(S_JUMP, addr_q, data_q);
            end else begin
              state <= S_ADDR;
              ctl_q <= ctl_for(S_ADDR, addr_q, data_q);
            end
          end
`ifdef DEBUG_SEQ_TIMEOUT_EN
          // Core never answered: give up without a RELEASE handshake.
          else if (to_cnt == TO_LAST) begin
            state     <= S_RESP;
            ctl_q     <= ctl_for(S_RESP, addr_q, data_q);
            err_q     <= 1'b1;
            rsp_err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end

        S_ADDR: begin
          if (!dbg.DEBUG_ACK) begin
            state <= S_RELEASE;
            ctl_q <= ctl_for(S_RELEASE, addr_q, data_q);
            err_q <= 1'b1;
          end else if (op_q == OP_WRITE) begin
            state <= S_DATA;
            ctl_q <= ctl_for(S_DATA, addr_q, data_q);
          end else begin
            state <= S_READ;
            ctl_q <= ctl_for(S_READ, addr_q, data_q);
          end
        end

        S_DATA, S_READ, S_JUMP: begin
          if (state == S_READ) begin
            rsp_data_q <= dbg.BUS;
          end
          if (!dbg.DEBUG_ACK) begin
            err_q <= 1'b1;
          end
          state <= S_RELEASE;
          ctl_q <= ctl_for(S_RELEASE, addr_q, data_q);
        end

        S_RELEASE: begin
          if (!dbg.DEBUG_ACK) begin
            state     <= S_RESP;
            ctl_q     <= ctl_for(S_RESP, addr_q, data_q);
            rsp_err_q <= err_q;
          end
        end

        S_RESP: begin
          state      <= S_IDLE;
          ctl_q      <= ctl_for(S_IDLE, addr_q, data_q);
          rsp_data_q <= 8'h00;
        end

        default: begin
          state <= S_IDLE;
          ctl_q <= ctl_for(S_IDLE, addr_q, data_q);
        end
      endcase
    end
  end

  assign dbg.CMD_READY     = ctl_q.ready;
  assign dbg.RSP_VALID     = ctl_q.valid;
  assign dbg.RSP_ERR       = rsp_err_q;
  assign dbg.RSP_DATA      = rsp_data_q;
  assign dbg.DEBUG_REQUEST = ctl_q.req;
  assign dbg.DEBUG_DATA    = ctl_q.dd;
  assign dbg.D_DOn         = ctl_q.do_n;
  assign dbg.D_MIn         = ctl_q.mi_n;
  assign dbg.D_ROn         = ctl_q.ro_n;
  assign dbg.D_Jn          = ctl_q.j_n;
  assign dbg.D_RI          = ctl_q.ri;

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: directed scenarios plus randomized commands checked
// cycle by cycle against a phase-list model of each transaction.
module tb_debug_sequencer;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 4;

  logic CLK = 1'b0;
  logic RESETn = 1'b1;
  always #5 CLK = ~CLK;

  debug_sequencer_if #(.ADDR_W(ADDR_W)) dbg_if ();

  debug_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .dbg    (dbg_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [24:0] outs;
    logic        ack;
    logic [7:0]  bus;
  } cyc_t;

  // {ready, valid, err, rsp_data, req, debug_data, do_n, mi_n, ro_n, j_n, ri}
  function automatic logic [24:0] mk(logic ready, logic valid, logic err, logic [7:0] rdata,
                                     logic req, logic [7:0] dd, logic do_n, logic mi_n,
                                     logic ro_n, logic j_n, logic ri);
    return {ready, valid, err, rdata, req, dd, do_n, mi_n, ro_n, j_n, ri};
  endfunction

  function automatic logic [24:0] observed();
    return {dbg_if.CMD_READY, dbg_if.RSP_VALID, dbg_if.RSP_ERR, dbg_if.RSP_DATA,
            dbg_if.DEBUG_REQUEST, dbg_if.DEBUG_DATA, dbg_if.D_DOn, dbg_if.D_MIn,
            dbg_if.D_ROn, dbg_if.D_Jn, dbg_if.D_RI};
  endfunction

  function automatic cyc_t cyc(logic [24:0] outs, logic ack, logic [7:0] bus);
    cyc_t c;
    c.outs = outs;
    c.ack  = ack;
    c.bus  = bus;
    return c;
  endfunction

  logic [24:0] idle_o;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [24:0] exp);
    logic [24:0] got;
    got = observed();
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Builds the expected per-cycle trace of one command, then drives and checks it.
  // drop_ph: index of the bus phase in which the core withdraws ack (-1 = never).
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] data, input int ack_dly, input int drop_ph,
                         input int rel_dly, input logic [7:0] bus_rd);
    cyc_t        tr[$];
    int          ph[$];
    logic        err;
    logic        timed_out;
    logic [7:0]  rd_val;
    logic [7:0]  a8;
    logic [24:0] req_o;
    logic [24:0] o;
    err = 1'b0;
    timed_out = 1'b0;
    rd_val = 8'h00;
    a8 = 8'(addr);
    req_o = mk(0, 0, 0, 8'h00, 1, 8'h00, 1, 1, 1, 1, 0);
    if (op == 2'b11) begin
      err = 1'b1;
    end else begin
`ifdef DEBUG_SEQ_TIMEOUT_EN
      if (ack_dly >= TIMEOUT) timed_out = 1'b1;
`endif
      if (timed_out) begin
        for (int i = 0; i < TIMEOUT; i++) tr.push_back(cyc(req_o, 1'b0, 8'($urandom)));
        err = 1'b1;
      end else begin
        for (int i = 0; i <= ack_dly; i++)
          tr.push_back(cyc(req_o, (i == ack_dly), 8'($urandom)));
        if (op == 2'b00)      ph = '{0, 1};
        else if (op == 2'b01) ph = '{0, 2};
        else                  ph = '{3};
        for (int k = 0; k < ph.size(); k++) begin
          logic [7:0] b;
          b = 8'($urandom);
          case (ph[k])
            0:       o = mk(0, 0, 0, 8'h00, 1, a8,   0, 0, 1, 1, 0);
            1:       o = mk(0, 0, 0, 8'h00, 1, data, 0, 1, 1, 1, 1);
            2:       begin o = mk(0, 0, 0, 8'h00, 1, 8'h00, 1, 1, 0, 1, 0); b = bus_rd; rd_val = bus_rd; end
            default: o = mk(0, 0, 0, 8'h00, 1, a8,   0, 1, 1, 0, 0);
          endcase
          tr.push_back(cyc(o, (k != drop_ph), b));
          if (k == drop_ph) begin
            err = 1'b1;
            break;
          end
        end
        o = mk(0, 0, 0, rd_val, 0, 8'h00, 1, 1, 1, 1, 0);
        if (err) tr.push_back(cyc(o, 1'b0, 8'($urandom)));
        else for (int i = 0; i <= rel_dly; i++) tr.push_back(cyc(o, (i < rel_dly), 8'($urandom)));
      end
    end
    tr.push_back(cyc(mk(0, 1, err, rd_val, 0, 8'h00, 1, 1, 1, 1, 0), 1'b0, 8'($urandom)));
    tr.push_back(cyc(idle_o, 1'b0, 8'($urandom)));

    dbg_if.CMD_OP    = op;
    dbg_if.CMD_ADDR  = addr;
    dbg_if.CMD_DATA  = data;
    dbg_if.CMD_VALID = 1'b1;
    dbg_if.DEBUG_ACK = 1'b0;
    dbg_if.BUS       = 8'($urandom);
    check({name, " idle"}, idle_o);
    tick();
    dbg_if.CMD_VALID = 1'b0;
    dbg_if.CMD_OP    = 2'($urandom);
    dbg_if.CMD_ADDR  = ADDR_W'($urandom);
    dbg_if.CMD_DATA  = 8'($urandom);
    for (int i = 0; i < tr.size(); i++) begin
      check($sformatf("%s c%0d", name, i), tr[i].outs);
      dbg_if.DEBUG_ACK = tr[i].ack;
      dbg_if.BUS       = tr[i].bus;
      tick();
    end
  endtask

  initial begin
    logic [1:0] r_op;
    int         r_dp;
    idle_o = mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 1, 1, 1, 0);
    dbg_if.CMD_VALID = 1'b0;
    dbg_if.CMD_OP    = 2'b00;
    dbg_if.CMD_ADDR  = '0;
    dbg_if.CMD_DATA  = 8'h00;
    dbg_if.DEBUG_ACK = 1'b0;
    dbg_if.BUS       = 8'h00;

    #2 RESETn = 1'b0;
    #1 check("reset_values", idle_o);
    tick();
    tick();
    RESETn = 1'b1;
    tick();
    check("after_reset", idle_o);

    run_cmd("wr_a5",    2'b00, 4'h3, 8'hA5, 2, -1, 1, 8'h00);
    run_cmd("rd_5c",    2'b01, 4'hF, 8'h00, 1, -1, 0, 8'h5C);
    run_cmd("op11",     2'b11, 4'h6, 8'h77, 0, -1, 0, 8'h00);
    run_cmd("pc_drop",  2'b10, 4'h7, 8'h00, 0,  0, 0, 8'h00);
    run_cmd("after_pc", 2'b00, 4'h1, 8'h42, 0, -1, 0, 8'h00);
    run_cmd("wr_dropd", 2'b00, 4'h2, 8'h99, 1,  1, 0, 8'h00);
    run_cmd("rd_dropa", 2'b01, 4'h4, 8'h00, 0,  0, 0, 8'hEE);

    // Reset pulsed in the middle of a write's DATA cycle.
    dbg_if.CMD_OP    = 2'b00;
    dbg_if.CMD_ADDR  = 4'h9;
    dbg_if.CMD_DATA  = 8'h3C;
    dbg_if.CMD_VALID = 1'b1;
    dbg_if.DEBUG_ACK = 1'b1;
    tick();
    dbg_if.CMD_VALID = 1'b0;
    check("rst_mid req",  mk(0, 0, 0, 8'h00, 1, 8'h00, 1, 1, 1, 1, 0));
    tick();
    check("rst_mid addr", mk(0, 0, 0, 8'h00, 1, 8'h09, 0, 0, 1, 1, 0));
    tick();
    check("rst_mid data", mk(0, 0, 0, 8'h00, 1, 8'h3C, 0, 1, 1, 1, 1));
    RESETn = 1'b0;
    #1 check("rst_mid async", idle_o);
    dbg_if.DEBUG_ACK = 1'b0;
    tick();
    RESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_mid quiet%0d", i), idle_o);
    end
    run_cmd("after_rst", 2'b01, 4'hA, 8'h00, 0, -1, 0, 8'h81);

`ifdef DEBUG_SEQ_TIMEOUT_EN
    run_cmd("timeout", 2'b00, 4'h5, 8'h11, 1000, -1, 0, 8'h00);
    run_cmd("after_to", 2'b10, 4'hC, 8'h00, 3, -1, 2, 8'h00);
`endif

    for (int t = 0; t < 40; t++) begin
      r_op = 2'($urandom_range(0, 3));
      r_dp = -1;
      if ($urandom_range(0, 3) == 0) r_dp = 0;
      else if (r_op == 2'b00 && $urandom_range(0, 3) == 0) r_dp = 1;
      run_cmd($sformatf("rnd%0d", t), r_op, ADDR_W'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), r_dp, int'($urandom_range(0, 2)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/debug_sequencer.md
DEBUG_SEQUENCER -- requirements
Module: debug_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4, the RAM address width; the address sits in DEBUG_DATA[ADDR_W-1:0] and the upper bits are zero.
REQ-002 Parameter TIMEOUT, default 255, the number of cycles to wait for ack; range 1..255.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESETn  input  1  asynchronous, active-low reset.
REQ-005 CMD_VALID  input  1  command offered.
REQ-006 CMD_READY  output  1  sequencer can accept a command.
REQ-007 CMD_OP  input  2  00 WRITE_MEM, 01 READ_MEM, 10 SET_PC, 11 reserved.
REQ-008 CMD_ADDR  input  ADDR_W  target address, or PC value for SET_PC.
REQ-009 CMD_DATA  input  8  write data; ignored except for WRITE_MEM.
REQ-010 RSP_VALID  output  1  one-cycle response pulse.
REQ-011 RSP_DATA  output  8  read data; zero for other ops.
REQ-012 RSP_ERR  output  1  command failed; qualified by RSP_VALID.
REQ-013 DEBUG_REQUEST  output  1  requests core debug ownership.
REQ-014 DEBUG_ACK  input  1  core grants ownership.
REQ-015 DEBUG_DATA  output  8  value the core drives onto its bus.
REQ-016 D_DOn, D_MIn, D_ROn, D_Jn  output  1 each  active-low debug controls: drive debug data, MAR-in, RAM-out, PC-load.
REQ-017 D_RI  output  1  active-high RAM-in.
REQ-018 BUS  input  8  core bus, sampled for reads.

Function
REQ-019 States SHALL be IDLE, REQ, ADDR, DATA, READ, JUMP, RELEASE and RESP; CMD_READY=1 only in IDLE.
REQ-020 A command SHALL be accepted on a cycle with CMD_VALID&CMD_READY; op, address and data are registered and the next state is REQ, or RESP with RSP_ERR=1 for op 11, with no debug request issued.
REQ-021 REQ: DEBUG_REQUEST=1 and all controls inactive; the first cycle DEBUG_ACK=1 is sampled moves to ADDR, or to JUMP for SET_PC. This includes ack already high on entry, which gives one cycle in REQ.
REQ-022 ADDR, exactly 1 cycle: DEBUG_DATA=address, D_DOn=0, D_MIn=0; then DATA for WRITE_MEM or READ for READ_MEM.
REQ-023 DATA, 1 cycle: DEBUG_DATA=CMD_DATA, D_DOn=0, D_RI=1.
REQ-024 READ, 1 cycle: D_ROn=0; BUS is captured at the end of the cycle into RSP_DATA.
REQ-025 JUMP, 1 cycle: DEBUG_DATA=address, D_DOn=0, D_Jn=0.
REQ-026 After DATA, READ or JUMP the state SHALL be RELEASE: DEBUG_REQUEST=0 and controls inactive, held until DEBUG_ACK=0 is sampled, then RESP.
REQ-027 RESP, 1 cycle: RSP_VALID=1; then IDLE. There is no response backpressure.
REQ-028 If DEBUG_ACK=0 during ADDR, DATA, READ or JUMP, the sequencer SHALL finish that cycle's controls, go to RELEASE and report RSP_ERR=1.
REQ-029 In every cycle outside ADDR, DATA and JUMP, DEBUG_DATA SHALL be 0x00.
REQ-030 At most one control strobe SHALL be active per cycle, besides D_DOn paired with its load.
REQ-031 Exactly one response SHALL be issued per accepted command.

Reset
REQ-032 RESETn=0 SHALL force IDLE immediately, including mid-transaction.
REQ-033 Reset values: CMD_READY=1 once out of reset, RSP_VALID=0, RSP_DATA=0x00, RSP_ERR=0, DEBUG_REQUEST=0, DEBUG_DATA=0x00, D_RI=0, and D_DOn/D_MIn/D_ROn/D_Jn=1.
REQ-034 A transaction interrupted by reset SHALL produce no response.

Configuration
REQ-035 Macro DEBUG_SEQ_TIMEOUT_EN defined: an 8-bit counter clears on entry to REQ and counts each REQ cycle without ack. If it reaches TIMEOUT, the sequencer drops DEBUG_REQUEST and goes directly to RESP with RSP_ERR=1, skipping RELEASE.
REQ-036 Macro undefined: REQ waits indefinitely and no counter logic is synthesized.

Verification
REQ-037 WRITE_MEM addr 0x3, data 0xA5, ack after 2 cycles -> ADDR shows DEBUG_DATA=0x03 with D_MIn=0; DATA shows 0xA5 with D_RI=1; after ack drops, RSP_VALID=1 and RSP_ERR=0.
REQ-038 READ_MEM addr 0xF with BUS=0x5C during READ -> RSP_DATA=0x5C, RSP_ERR=0; D_ROn=0 for exactly one cycle.
REQ-039 Op 11 -> DEBUG_REQUEST never rises; RSP_VALID with RSP_ERR=1 one cycle after accept.
REQ-040 SET_PC 0x7 with ack dropped during JUMP -> D_Jn=0 for one cycle, then RSP_ERR=1; a new command is accepted afterwards.
REQ-041 RESETn pulsed low during DATA -> all outputs reach their reset values immediately and no RSP_VALID follows.
REQ-042 With DEBUG_SEQ_TIMEOUT_EN and TIMEOUT=4, ack never asserted -> DEBUG_REQUEST high for 4 cycles, then RSP_ERR=1.
